// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Latency: hits complete in 0 cycles (combinational read, store on the same edge);
//          misses stall for WORDS*(L+1)+1 cycles, doubled refill time if a dirty victim is written back.
// Backpressure: raises miss to stall the core; each memory word waits for a one-cycle mem_ack.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rd_req, wr_req[3:0]  load request / store byte enables (any bit set = store)
//   addr, wr_data        byte address and lane-aligned store data
//   rd_data, miss        load result and stall request
//   mem_*                word-serial main-memory read/write port
//   hit_count/miss_count performance counters (wrap modulo 2^32)
module data_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [3:0]  wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS    = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Line storage: control bits are reset, tags and data are don't-care after reset.
  logic [SETS-1:0]    r_valid;
  logic [SETS-1:0]    r_dirty;
  logic [TAG_LEN-1:0] r_tag  [SETS];
  logic [31:0]        r_data [SETS][WORDS];

  // Pending miss: only these are used while WB/REFILL runs.
  logic [TAG_LEN-1:0]       r_pend_tag;
  logic [SET_ADDR_LEN-1:0]  r_pend_set;
  logic [LINE_ADDR_LEN-1:0] r_word_cnt;

  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Address decode of the live request.
  logic [LINE_ADDR_LEN-1:0] w_word;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [TAG_LEN-1:0]       w_tag;
  logic [1:0]               w_unused_addr_lsb;

  assign w_word            = addr[2 +: LINE_ADDR_LEN];
  assign w_set             = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign w_tag             = addr[31 -: TAG_LEN];
  assign w_unused_addr_lsb = addr[1:0];

  logic w_req;
  logic w_store;
  logic w_idle;
  logic w_hit;
  logic w_complete;
  logic w_start_miss;
  logic w_last;
  logic w_wb_ack;
  logic w_refill_ack;

  assign w_req        = rd_req | (|wr_req);
  assign w_store      = |wr_req;
  assign w_idle       = (r_state == S_IDLE);
  assign w_hit        = r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_complete   = w_idle && w_req && w_hit;
  assign w_start_miss = w_idle && w_req && !w_hit;
  assign w_last       = (r_word_cnt == LINE_ADDR_LEN'(WORDS - 1));
  assign w_wb_ack     = (r_state == S_WB) && mem_ack;
  assign w_refill_ack = (r_state == S_REFILL) && mem_ack;

  // Stall covers the whole miss sequence and drops in the IDLE cycle where the held request hits.
  assign miss = w_req && (!w_idle || !w_hit);

  // On a combined load+store the pre-store word is returned, since the store lands at the edge.
  assign rd_data = (w_idle && rd_req && w_hit) ? r_data[w_set][w_word] : 32'd0;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Next-state and memory-port outputs.
  always_comb begin
    w_state_nxt = r_state;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_start_miss) begin
          if (r_valid[w_set] && r_dirty[w_set]) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt = S_REFILL;
          end
        end
      end
      S_WB: begin
        // Victim address is rebuilt from the tag still resident in the set.
        mem_wr_req = 1'b1;
        mem_addr   = {r_tag[r_pend_set], r_pend_set, r_word_cnt, 2'b00};
        mem_wdata  = r_data[r_pend_set][r_word_cnt];
        if (mem_ack && w_last) begin
          w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = {r_pend_tag, r_pend_set, r_word_cnt, 2'b00};
        if (mem_ack && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, line status bits and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_pend_tag   <= '0;
      r_pend_set   <= '0;
      r_word_cnt   <= '0;
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_miss) begin
        r_pend_tag   <= w_tag;
        r_pend_set   <= w_set;
        r_word_cnt   <= '0;
        r_miss_count <= r_miss_count + 32'd1;
      end

      if (w_complete) begin
        r_hit_count <= r_hit_count + 32'd1;
        if (w_store) begin
          r_dirty[w_set] <= 1'b1;
        end
      end

      // Counter wraps naturally to 0 after the last word, ready for the next phase.
      if (w_wb_ack || w_refill_ack) begin
        r_word_cnt <= r_word_cnt + LINE_ADDR_LEN'(1);
      end

      if (w_wb_ack && w_last) begin
        r_dirty[r_pend_set] <= 1'b0;
      end

      if (w_refill_ack && w_last) begin
        r_valid[r_pend_set] <= 1'b1;
        r_dirty[r_pend_set] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: no reset needed, validity is tracked by r_valid.
  always_ff @(posedge clk) begin
    if (w_complete && w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_req[b]) begin
          r_data[w_set][w_word][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (w_refill_ack) begin
      r_data[r_pend_set][r_word_cnt] <= mem_rdata;
    end
    if (w_refill_ack && w_last) begin
      r_tag[r_pend_set] <= r_pend_tag;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed plus randomized checks of data_cache against a line-level reference model.
// Memory side is a word-serial responder with a configurable number of wait cycles per word.
module tb_data_cache;

  localparam int WORDS = 8;
  localparam int SETS  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [3:0]  wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  data_cache #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .miss       (miss),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;

  // Environment memory and observed transfers.
  logic [31:0] emem [logic [31:0]];
  logic [31:0] ob_wb_addr [$];
  logic [31:0] ob_wb_dat  [$];
  logic [31:0] ob_rf_addr [$];

  // Reference model: whole lines, plain arrays.
  logic [31:0] ref_mem [logic [31:0]];
  bit          rm_valid [SETS];
  bit          rm_dirty [SETS];
  logic [24:0] rm_tag   [SETS];
  logic [31:0] rm_data  [SETS][WORDS];
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  // Untouched memory: word at 0x40+4i holds 0x100+i.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'h100 + ((a - 32'h40) >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      rm_valid[s] = 1'b0;
      rm_dirty[s] = 1'b0;
    end
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
  endtask

  // Memory responder: ack after mem_lat wait cycles, one word at a time.
  initial begin : mem_env
    int wcnt;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        chk("mem_req_exclusive", {31'd0, mem_rd_req & mem_wr_req}, 32'd0);
        if (wcnt >= mem_lat) begin
          wcnt    = 0;
          mem_ack = 1'b1;
          if (mem_rd_req) begin
            mem_rdata = emem.exists(mem_addr) ? emem[mem_addr] : dflt(mem_addr);
            ob_rf_addr.push_back(mem_addr);
          end else begin
            emem[mem_addr] = mem_wdata;
            ob_wb_addr.push_back(mem_addr);
            ob_wb_dat.push_back(mem_wdata);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // One access, called at posedge+1. Checks stall length, load data, counters and memory traffic.
  task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] obs_rd, output int obs_cyc);
    int          set;
    int          w;
    int          exp_cyc;
    logic [24:0] tg;
    logic [31:0] old;
    logic [31:0] nw;
    logic [31:0] wa;
    logic [31:0] exp_wb_a [$];
    logic [31:0] exp_wb_d [$];
    logic [31:0] exp_rf   [$];
    set     = int'(a[6:5]);
    w       = int'(a[4:2]);
    tg      = a[31:7];
    exp_cyc = 0;
    if (!(rm_valid[set] && rm_tag[set] == tg)) begin
      exp_misses++;
      exp_cyc = 1;
      if (rm_valid[set] && rm_dirty[set]) begin
        for (int i = 0; i < WORDS; i++) begin
          wa = {rm_tag[set], 2'(set), 3'(i), 2'b00};
          exp_wb_a.push_back(wa);
          exp_wb_d.push_back(rm_data[set][i]);
          ref_mem[wa] = rm_data[set][i];
        end
        exp_cyc += WORDS * (mem_lat + 1);
      end
      for (int i = 0; i < WORDS; i++) begin
        wa = {tg, 2'(set), 3'(i), 2'b00};
        exp_rf.push_back(wa);
        rm_data[set][i] = ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
      end
      exp_cyc += WORDS * (mem_lat + 1);
      rm_valid[set] = 1'b1;
      rm_tag[set]   = tg;
      rm_dirty[set] = 1'b0;
    end
    old = rm_data[set][w];
    nw  = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
    end
    if (be != 4'h0) begin
      rm_data[set][w] = nw;
      rm_dirty[set]   = 1'b1;
    end
    exp_hits++;

    ob_wb_addr.delete();
    ob_wb_dat.delete();
    ob_rf_addr.delete();
    rd_req  = rd;
    wr_req  = be;
    addr    = a;
    wr_data = wd;
    obs_cyc = 0;
    @(negedge clk);
    while (miss && obs_cyc < 2000) begin
      obs_cyc++;
      @(negedge clk);
    end
    obs_rd = rd_data;
    chk({tag, "/stall_cycles"}, 32'(obs_cyc), 32'(exp_cyc));
    if (rd) chk({tag, "/rd_data"}, rd_data, old);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 4'h0;
    chk({tag, "/hit_count"}, hit_count, exp_hits);
    chk({tag, "/miss_count"}, miss_count, exp_misses);
    chk({tag, "/wb_words"}, 32'(ob_wb_addr.size()), 32'(exp_wb_a.size()));
    chk({tag, "/rf_words"}, 32'(ob_rf_addr.size()), 32'(exp_rf.size()));
    for (int i = 0; i < exp_wb_a.size() && i < ob_wb_addr.size(); i++) begin
      chk({tag, "/wb_addr"}, ob_wb_addr[i], exp_wb_a[i]);
      chk({tag, "/wb_data"}, ob_wb_dat[i], exp_wb_d[i]);
    end
    for (int i = 0; i < exp_rf.size() && i < ob_rf_addr.size(); i++) begin
      chk({tag, "/rf_addr"}, ob_rf_addr[i], exp_rf[i]);
    end
  endtask

  initial begin : main
    logic [31:0] r;
    int          c;
    logic [31:0] hc0;
    logic [31:0] a;
    logic [3:0]  be;
    logic        rd;

    rst_n   = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 4'h0;
    addr    = 32'd0;
    wr_data = 32'd0;
    model_reset();
    #12;
    chk("rst/hit_count", hit_count, 32'd0);
    chk("rst/miss_count", miss_count, 32'd0);
    chk("rst/miss", {31'd0, miss}, 32'd0);
    chk("rst/rd_data", rd_data, 32'd0);
    chk("rst/mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst/mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean miss with two wait cycles per word.
    mem_lat = 2;
    access(1'b1, 4'h0, 32'h40, 32'd0, "ld40", r, c);
    chk("ld40/stall_25", 32'(c), 32'd25);
    chk("ld40/word0", r, 32'h100);
    chk("ld40/miss_count", miss_count, 32'd1);
    chk("ld40/hit_count", hit_count, 32'd1);

    // Byte-lane store hit, then read back the merged word.
    access(1'b0, 4'b0010, 32'h44, 32'hAABBCCDD, "st44", r, c);
    chk("st44/no_stall", 32'(c), 32'd0);
    access(1'b1, 4'h0, 32'h44, 32'd0, "ld44", r, c);
    chk("ld44/merged", r, 32'h0000CC01);

    // Conflict miss evicts the dirty line.
    access(1'b1, 4'h0, 32'h240, 32'd0, "ld240", r, c);
    chk("ld240/stall_49", 32'(c), 32'd49);
    chk("ld240/wb_word1", (ob_wb_dat.size() > 1) ? ob_wb_dat[1] : 32'hx, 32'h0000CC01);
    chk("ld240/wb_first_addr", (ob_wb_addr.size() > 0) ? ob_wb_addr[0] : 32'hx, 32'h40);

    // Back-to-back hits across the resident line.
    hc0 = exp_hits;
    for (int i = 0; i < WORDS; i++) begin
      access(1'b1, 4'h0, 32'h240 + 32'(4 * i), 32'd0, "b2b", r, c);
    end
    chk("b2b/hit_count_plus8", hit_count, hc0 + 32'd8);

    // Combined load+store returns the pre-store word.
    access(1'b1, 4'hF, 32'h248, 32'hDEADBEEF, "rdwr", r, c);
    chk("rdwr/old_word", r, 32'h182);
    access(1'b1, 4'h0, 32'h248, 32'd0, "rdwr_after", r, c);
    chk("rdwr_after/new_word", r, 32'hDEADBEEF);
    access(1'b1, 4'h0, 32'h40, 32'd0, "evict240", r, c);
    chk("evict240/wb_word2", (ob_wb_dat.size() > 2) ? ob_wb_dat[2] : 32'hx, 32'hDEADBEEF);

    // Reset in the middle of a refill.
    ob_rf_addr.delete();
    rd_req = 1'b1;
    addr   = 32'h340;
    c      = 0;
    while (!(mem_rd_req && mem_addr == 32'h354) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("rstmid/words_before", 32'(ob_rf_addr.size()), 32'd5);
    rst_n  = 1'b0;
    rd_req = 1'b0;
    #1;
    chk("rstmid/miss", {31'd0, miss}, 32'd0);
    chk("rstmid/mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rstmid/mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
    chk("rstmid/mem_addr", mem_addr, 32'd0);
    chk("rstmid/mem_wdata", mem_wdata, 32'd0);
    chk("rstmid/hit_count", hit_count, 32'd0);
    chk("rstmid/miss_count", miss_count, 32'd0);
    chk("rstmid/rd_data", rd_data, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 4'h0, 32'h340, 32'd0, "post_rst", r, c);
    chk("post_rst/stall_25", 32'(c), 32'd25);

    // Randomized accesses over four tags, all sets and words.
    for (int n = 0; n < 60; n++) begin
      mem_lat = int'($urandom_range(0, 2));
      a  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      rd = (be == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
      access(rd, be, a, $urandom(), "rnd", r, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
